// File: rtl/mips_cpu_control.sv
// mips_cpu_control: multicycle main control FSM for the MIPS CPU.
// Sequences each instruction through FETCH -> EXEC -> (MEM) -> (WB), waits in
// MDWAIT for the mul/div unit and halts on a fetch from address 0.
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   op, func             opcode/function fields from the instruction register
//   waitrequest          memory stall; a transfer completes when the strobe is
//                        high and waitrequest is low
//   pc_is_zero           PC == 0 (halt condition checked at fetch)
//   md_done              mul/div result ready
//   IRWrite, IR_sel      IR load strobe and IR pass-through select
//   mem_read, mem_write  memory strobes; i_or_d selects PC (0) or ALU (1) address
//   pc_write, branch     unconditional / conditional PC load; pc_src picks source
//   reg_write            register-file write enable
//   md_start             one-cycle mul/div start pulse
//   active, fault        CPU running; sticky undefined-instruction flag
// All outputs except fault are combinational from state, op, func and
// waitrequest, so an asynchronous reset clears them in the same cycle.

module mips_cpu_control #(
  parameter bit ENABLE_MD = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       waitrequest,
  input  logic       pc_is_zero,
  input  logic       md_done,
  output logic       IRWrite,
  output logic       IR_sel,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       pc_write,
  output logic       branch,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       md_start,
  output logic       active,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_MDWAIT,
    S_HALTED
  } state_t;

  localparam logic [1:0] SRC_PC4    = 2'd0;
  localparam logic [1:0] SRC_BRANCH = 2'd1;
  localparam logic [1:0] SRC_JUMP   = 2'd2;
  localparam logic [1:0] SRC_RS     = 2'd3;

  state_t state;
  state_t state_nxt;
  logic   fault_q;
  logic   fault_set;

  // ---------------------------------------------------------------------------
  // Instruction classification. Outside FETCH, IR_sel is 0, so op/func are the
  // stored instruction and stay stable through EXEC, MEM and WB.
  // ---------------------------------------------------------------------------
  logic is_rtype;
  logic is_jr;
  logic is_jalr;
  logic is_md;
  logic is_ralu;
  logic is_imm;
  logic is_load;
  logic is_store;
  logic is_branch;
  logic is_j;
  logic is_jal;

  always_comb begin
    is_rtype  = (op == 6'h00);
    is_jr     = is_rtype && (func == 6'h08);
    is_jalr   = is_rtype && (func == 6'h09);
    // func 0x18..0x1B share the upper four bits 4'b0110
    is_md     = is_rtype && (func[5:2] == 4'b0110);
    is_ralu   = is_rtype && !is_jr && !is_jalr && !is_md;
    is_imm    = (op[5:3] == 3'b001);                        // 0x08..0x0F
    is_load   = (op[5:3] == 3'b100) && (op[2:0] != 3'b111); // 0x20..0x26
    is_store  = (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
    is_branch = (op == 6'h01) || (op[5:2] == 4'b0001);      // 0x01, 0x04..0x07
    is_j      = (op == 6'h02);
    is_jal    = (op == 6'h03);
  end

  // ---------------------------------------------------------------------------
  // State register and sticky fault flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      fault_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (fault_set) begin
        fault_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    fault_set = 1'b0;
    IRWrite   = 1'b0;
    IR_sel    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    i_or_d    = 1'b0;
    pc_write  = 1'b0;
    branch    = 1'b0;
    pc_src    = SRC_PC4;
    reg_write = 1'b0;
    md_start  = 1'b0;
    active    = 1'b0;

    unique case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
      end

      S_FETCH: begin
        active = 1'b1;
        if (pc_is_zero) begin
          // A jump to address 0 means the program is finished: no read issued.
          state_nxt = S_HALTED;
        end else begin
          mem_read = 1'b1;
          i_or_d   = 1'b0;
          if (!waitrequest) begin
            // Data is on the bus this cycle: pass it through the IR so EXEC
            // decodes the new instruction, and advance PC to PC+4.
            IRWrite   = 1'b1;
            IR_sel    = 1'b1;
            pc_write  = 1'b1;
            pc_src    = SRC_PC4;
            state_nxt = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        active = 1'b1;
        IR_sel = 1'b0;
        if (is_ralu || is_imm) begin
          state_nxt = S_WB;
        end else if (is_load || is_store) begin
          state_nxt = S_MEM;
        end else if (is_branch) begin
          branch    = 1'b1;
          pc_src    = SRC_BRANCH;
          state_nxt = S_FETCH;
        end else if (is_j || is_jal) begin
          pc_write  = 1'b1;
          pc_src    = SRC_JUMP;
          state_nxt = is_jal ? S_WB : S_FETCH;
        end else if (is_jr || is_jalr) begin
          pc_write  = 1'b1;
          pc_src    = SRC_RS;
          state_nxt = is_jalr ? S_WB : S_FETCH;
        end else if (is_md && ENABLE_MD) begin
          // EXEC lasts a single cycle, so this is a one-cycle pulse.
          md_start  = 1'b1;
          state_nxt = S_MDWAIT;
        end else begin
          fault_set = 1'b1;
          state_nxt = S_HALTED;
        end
      end

      S_MEM: begin
        active    = 1'b1;
        i_or_d    = 1'b1;
        // Strobe depends only on the stored op, so it is stable across stalls.
        mem_read  = is_load;
        mem_write = is_store;
        if (!waitrequest) begin
          state_nxt = is_load ? S_WB : S_FETCH;
        end
      end

      S_WB: begin
        active    = 1'b1;
        reg_write = 1'b1;
        state_nxt = S_FETCH;
      end

      S_MDWAIT: begin
        active = 1'b1;
        if (md_done) begin
          state_nxt = S_FETCH;
        end
      end

      S_HALTED: begin
        state_nxt = S_HALTED;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign fault = fault_q;

endmodule

// File: tb/tb_mips_cpu_control.sv
// tb_mips_cpu_control: directed bench for mips_cpu_control.
// Two instances share all inputs: dut (ENABLE_MD=1) and dut_nomd (ENABLE_MD=0).
// Each cycle the expected output vector is queued when inputs are driven and
// popped for comparison at the falling edge.

module tb_mips_cpu_control;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] func;
  logic       waitrequest;
  logic       pc_is_zero;
  logic       md_done;

  logic       IRWrite, IR_sel, mem_read, mem_write, i_or_d, pc_write, branch;
  logic [1:0] pc_src;
  logic       reg_write, md_start, active, fault;

  logic       n_IRWrite, n_IR_sel, n_mem_read, n_mem_write, n_i_or_d, n_pc_write, n_branch;
  logic [1:0] n_pc_src;
  logic       n_reg_write, n_md_start, n_active, n_fault;

  mips_cpu_control #(.ENABLE_MD(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .waitrequest(waitrequest),
    .pc_is_zero(pc_is_zero), .md_done(md_done),
    .IRWrite(IRWrite), .IR_sel(IR_sel), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .pc_write(pc_write), .branch(branch), .pc_src(pc_src),
    .reg_write(reg_write), .md_start(md_start), .active(active), .fault(fault)
  );

  mips_cpu_control #(.ENABLE_MD(1'b0)) dut_nomd (
    .clk(clk), .reset(reset), .op(op), .func(func), .waitrequest(waitrequest),
    .pc_is_zero(pc_is_zero), .md_done(md_done),
    .IRWrite(n_IRWrite), .IR_sel(n_IR_sel), .mem_read(n_mem_read), .mem_write(n_mem_write),
    .i_or_d(n_i_or_d), .pc_write(n_pc_write), .branch(n_branch), .pc_src(n_pc_src),
    .reg_write(n_reg_write), .md_start(n_md_start), .active(n_active), .fault(n_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector layout:
  // [12] IRWrite [11] IR_sel [10] mem_read [9] mem_write [8] i_or_d [7] pc_write
  // [6] branch [5:4] pc_src [3] reg_write [2] md_start [1] active [0] fault
  localparam logic [12:0] B_IRW = 13'h1000;
  localparam logic [12:0] B_IRS = 13'h0800;
  localparam logic [12:0] B_RD  = 13'h0400;
  localparam logic [12:0] B_WR  = 13'h0200;
  localparam logic [12:0] B_IOD = 13'h0100;
  localparam logic [12:0] B_PCW = 13'h0080;
  localparam logic [12:0] B_BR  = 13'h0040;
  localparam logic [12:0] SRC1  = 13'h0010;
  localparam logic [12:0] SRC2  = 13'h0020;
  localparam logic [12:0] SRC3  = 13'h0030;
  localparam logic [12:0] B_RW  = 13'h0008;
  localparam logic [12:0] B_MDS = 13'h0004;
  localparam logic [12:0] B_ACT = 13'h0002;
  localparam logic [12:0] B_FLT = 13'h0001;

  localparam logic [12:0] X_IDLE   = 13'h0000;
  localparam logic [12:0] X_FDONE  = B_IRW | B_IRS | B_RD | B_PCW | B_ACT;
  localparam logic [12:0] X_FWAIT  = B_RD | B_ACT;
  localparam logic [12:0] X_FZERO  = B_ACT;
  localparam logic [12:0] X_ACT    = B_ACT;
  localparam logic [12:0] X_BRANCH = B_BR | SRC1 | B_ACT;
  localparam logic [12:0] X_JR     = B_PCW | SRC3 | B_ACT;
  localparam logic [12:0] X_MDS    = B_MDS | B_ACT;
  localparam logic [12:0] X_LOAD   = B_IOD | B_RD | B_ACT;
  localparam logic [12:0] X_STORE  = B_IOD | B_WR | B_ACT;
  localparam logic [12:0] X_WB     = B_RW | B_ACT;

  typedef struct {
    string       tag;
    logic [12:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  vectors;
  int  miscompares;

  function automatic logic [12:0] obs_vec();
    return {IRWrite, IR_sel, mem_read, mem_write, i_or_d, pc_write, branch,
            pc_src, reg_write, md_start, active, fault};
  endfunction

  task automatic compare_head();
    sb_t         e;
    logic [12:0] o;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed 0 entries required at least 1");
      return;
    end
    e = sb_q.pop_front();
    o = obs_vec();
    vectors++;
    assert (o === e.exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b required %b", e.tag, o, e.exp);
    end
  endtask

  // One clock cycle: drive inputs, queue the expectation, compare at negedge.
  task automatic cyc(input string tag, input logic [5:0] o, input logic [5:0] f,
                     input logic wr, input logic pcz, input logic mdd,
                     input logic [12:0] exp);
    sb_t e;
    op          = o;
    func        = f;
    waitrequest = wr;
    pc_is_zero  = pcz;
    md_done     = mdd;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    @(negedge clk);
    compare_head();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_nomd(input string tag, input logic exp_act, input logic exp_flt);
    vectors++;
    assert ({n_active, n_fault} === {exp_act, exp_flt}) else begin
      miscompares++;
      $error("FAIL %s: observed active/fault %b%b required %b%b",
             tag, n_active, n_fault, exp_act, exp_flt);
    end
  endtask

  initial begin
    sb_t e;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    op          = 6'h00;
    func        = 6'h00;
    waitrequest = 1'b0;
    pc_is_zero  = 1'b0;
    md_done     = 1'b0;

    @(posedge clk);
    #1;
    cyc("reset_held", 6'h00, 6'h21, 1'b0, 1'b0, 1'b0, X_IDLE);
    reset = 1'b0;
    cyc("idle_after_release", 6'h00, 6'h21, 1'b0, 1'b0, 1'b0, X_IDLE);

    // ADDU: 3 cycles FETCH to FETCH
    cyc("addu_fetch", 6'h00, 6'h21, 1'b0, 1'b0, 1'b0, X_FDONE);
    cyc("addu_exec",  6'h00, 6'h21, 1'b0, 1'b0, 1'b0, X_ACT);
    cyc("addu_wb",    6'h00, 6'h21, 1'b0, 1'b0, 1'b0, X_WB);

    // LW with 3 wait states in MEM: 7 cycles FETCH to FETCH
    cyc("lw_fetch", 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, X_FDONE);
    cyc("lw_exec",  6'h23, 6'h00, 1'b0, 1'b0, 1'b0, X_ACT);
    for (int i = 0; i < 3; i++)
      cyc("lw_mem_stall", 6'h23, 6'h00, 1'b1, 1'b0, 1'b0, X_LOAD);
    cyc("lw_mem_done", 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, X_LOAD);
    cyc("lw_wb",       6'h23, 6'h00, 1'b0, 1'b0, 1'b0, X_WB);

    // Stalled fetch holds mem_read without IR/PC strobes
    cyc("fetch_stall", 6'h2B, 6'h00, 1'b1, 1'b0, 1'b0, X_FWAIT);

    // SW: store strobe, no register write, straight back to FETCH
    cyc("sw_fetch", 6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, X_FDONE);
    cyc("sw_exec",  6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, X_ACT);
    cyc("sw_mem",   6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, X_STORE);

    // BEQ: branch only in EXEC
    cyc("beq_fetch", 6'h04, 6'h00, 1'b0, 1'b0, 1'b0, X_FDONE);
    cyc("beq_exec",  6'h04, 6'h00, 1'b0, 1'b0, 1'b0, X_BRANCH);

    // DIVU: one-cycle start pulse, 10 cycles in MDWAIT
    cyc("divu_fetch", 6'h00, 6'h1B, 1'b0, 1'b0, 1'b0, X_FDONE);
    cyc("divu_exec",  6'h00, 6'h1B, 1'b0, 1'b0, 1'b0, X_MDS);
    chk_nomd("nomd_halted_fault", 1'b0, 1'b1);
    for (int i = 0; i < 9; i++)
      cyc("divu_mdwait", 6'h00, 6'h1B, 1'b0, 1'b0, 1'b0, X_ACT);
    cyc("divu_mdwait_done", 6'h00, 6'h1B, 1'b0, 1'b0, 1'b1, X_ACT);
    chk_nomd("nomd_fault_sticky", 1'b0, 1'b1);

    // JR to 0, then the fetch from PC 0 halts without a read
    cyc("jr_fetch", 6'h00, 6'h08, 1'b0, 1'b0, 1'b0, X_FDONE);
    cyc("jr_exec",  6'h00, 6'h08, 1'b0, 1'b0, 1'b0, X_JR);
    cyc("fetch_pc_zero", 6'h00, 6'h08, 1'b0, 1'b1, 1'b0, X_FZERO);
    cyc("halted",        6'h00, 6'h21, 1'b0, 1'b1, 1'b0, X_IDLE);
    cyc("halted_absorb", 6'h00, 6'h21, 1'b0, 1'b0, 1'b0, X_IDLE);

    // Restart from reset, then reset mid-MEM while stalled
    reset = 1'b1;
    cyc("reset_from_halt", 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, X_IDLE);
    reset = 1'b0;
    cyc("idle_restart", 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, X_IDLE);
    cyc("lw2_fetch", 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, X_FDONE);
    cyc("lw2_exec",  6'h23, 6'h00, 1'b0, 1'b0, 1'b0, X_ACT);

    waitrequest = 1'b1;
    e.tag = "lw2_mem_stall";
    e.exp = X_LOAD;
    sb_q.push_back(e);
    @(negedge clk);
    compare_head();
    reset = 1'b1;
    #1;
    e.tag = "async_reset_drop";
    e.exp = X_IDLE;
    sb_q.push_back(e);
    compare_head();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("idle_after_async", 6'h00, 6'h21, 1'b0, 1'b0, 1'b0, X_IDLE);
    cyc("refetch", 6'h00, 6'h21, 1'b0, 1'b0, 1'b0, X_FDONE);
    cyc("refetch_exec", 6'h00, 6'h21, 1'b0, 1'b0, 1'b0, X_ACT);
    cyc("refetch_wb",   6'h00, 6'h21, 1'b0, 1'b0, 1'b0, X_WB);
    cyc("refetch_next", 6'h00, 6'h21, 1'b1, 1'b0, 1'b0, X_FWAIT);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_cpu_control.md
Name: mips_cpu_control

Overview:
- Multicycle main control FSM for the MIPS CPU; sits directly downstream of the instruction register.
- Consumes decoded op/func fields and the memory bus handshake.
- Drives the IR load strobes (IRWrite, IR_sel), memory read/write strobes, PC update controls and register-file write enable.
- Sequences each instruction through FETCH/EXEC/MEM/WB, waits on the multiply/divide unit, and halts on a jump to address 0.

Parameters:
- ENABLE_MD, 1, when 1 MULT/MULTU/DIV/DIVU (op=0, func 0x18-0x1B) start the mul/div unit; when 0 they are undefined instructions.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- op  input  6  opcode field from IR (IR_sel-selected).
- func  input  6  function field from IR.
- waitrequest  input  1  memory bus stall; a transfer completes in a cycle where the strobe is high and waitrequest=0.
- pc_is_zero  input  1  high when PC==0x00000000.
- md_done  input  1  mul/div unit result ready.
- IRWrite  output  1  load IR from memory data.
- IR_sel  output  1  1 = IR outputs pass memory data through, 0 = stored instruction.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- i_or_d  output  1  address select: 0 = PC, 1 = ALU result.
- pc_write  output  1  unconditional PC load.
- branch  output  1  conditional PC load, gated by ALU condition in datapath.
- pc_src  output  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = register rs.
- reg_write  output  1  register-file write enable.
- md_start  output  1  one-cycle start pulse to mul/div unit.
- active  output  1  CPU running.
- fault  output  1  sticky undefined-instruction flag.

Behaviour:
- All outputs are Moore/Mealy combinational from state, op, func and waitrequest. Default value of every output is 0, pc_src default 0.
- Reset (asynchronous): state goes to IDLE immediately. All outputs go to 0 in the same cycle, including active and fault. Any in-flight mem_read/mem_write is dropped.
- States: IDLE, FETCH, EXEC, MEM, WB, MDWAIT, HALTED.
- IDLE: all outputs 0. First rising edge with reset=0 moves to FETCH.
- FETCH:
  - active=1.
  - If pc_is_zero=1: no read; next state HALTED.
  - Otherwise mem_read=1, i_or_d=0.
  - While waitrequest=1: hold all of the above and stay in FETCH.
  - On the completing cycle (waitrequest=0): IRWrite=1, IR_sel=1, pc_write=1, pc_src=0; next state EXEC.
- EXEC: IR_sel=0. Classification on the stored op/func:
  - R-type ALU (op=0, func not 0x08/0x09/0x18-0x1B) and immediates (op 0x08-0x0F): next WB.
  - Loads (op 0x20-0x26) and stores (op 0x28, 0x29, 0x2B): next MEM.
  - Branches (op 0x01, 0x04-0x07): branch=1, pc_src=1; next FETCH.
  - J (op 0x02): pc_write=1, pc_src=2; next FETCH.
  - JAL (op 0x03): pc_write=1, pc_src=2; next WB.
  - JR (func 0x08): pc_write=1, pc_src=3; next FETCH.
  - JALR (func 0x09): pc_write=1, pc_src=3; next WB.
  - MULT/DIV with ENABLE_MD=1: md_start=1 (exactly one cycle); next MDWAIT.
  - Any other encoding: fault set; next HALTED.
- MEM:
  - i_or_d=1; mem_read=1 for loads, mem_write=1 for stores.
  - Stay while waitrequest=1, with the strobe held stable.
  - On completion: loads go to WB, stores go to FETCH.
- WB: reg_write=1 for exactly one cycle; next FETCH.
- MDWAIT: all strobes 0. Stay until md_done=1, then FETCH. If md_done is already high on entry, leave after one cycle.
- HALTED: active=0, fault holds its value, all strobes 0. State is absorbing until reset.
- mem_read and mem_write are never high together. No strobe changes while waitrequest=1 within a transfer.
- Latency with zero wait states, counted as cycles from FETCH entry to the next FETCH:
  - ALU/immediate: 3
  - load: 4
  - store: 3
  - branch/jump: 2

Test Plan:
- Reset release, pc_is_zero=0, waitrequest=0, op=0x00 func=0x21 (ADDU) -> FETCH(mem_read=1, IRWrite=1, IR_sel=1, pc_write=1), EXEC, WB(reg_write=1), FETCH; active=1 throughout.
- LW (op=0x23) with waitrequest held high 3 cycles in MEM -> mem_read=1, i_or_d=1 stable for 4 cycles, then WB with reg_write=1; 7 cycles FETCH-to-FETCH including a 0-wait fetch.
- SW (op=0x2B), then BEQ (op=0x04) -> store gives mem_write=1 and no reg_write; BEQ gives branch=1, pc_src=1 in EXEC only.
- DIVU (func 0x1B) with md_done asserted 10 cycles later -> md_start high exactly 1 cycle, MDWAIT for 10 cycles, then FETCH; repeat with ENABLE_MD=0 -> fault=1, active=0.
- JR to 0 (func 0x08), then pc_is_zero=1 in FETCH -> pc_src=3, pc_write=1; next FETCH issues no mem_read; HALTED with active=0, fault=0.
- Assert reset mid-MEM while waitrequest=1 -> mem_read drops to 0 in the same cycle, state IDLE; after release, fetch restarts cleanly.
